mem_wb: RTL and testbench
=========================

Name: mem_wb

Overview:
- MEM/WB pipeline boundary register of the 16-bit multi-cycle/pipelined CPU (mcpu).
- Captures the register-file write request produced by the memory stage: data, destination register and write enable.
- Presents that request, one clock later, to the write-back stage and register file.
- Pure storage block: no decoding, no arithmetic, no stall or flush inputs.

Parameters:
- DATA_W, 16, width of write-back data (machine word).
- ADDR_W, 4, width of register-file address (16 general registers).

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high (RstEnable = 1'b1, RstDisable = 1'b0).
- mem_wdata  input  DATA_W  result to be written back, from MEM stage.
- mem_waddr  input  ADDR_W  destination register index, from MEM stage.
- mem_we  input  1  register write enable from MEM stage (WriteEnable = 1'b1, WriteDisable = 1'b0).
- wb_wdata  output  DATA_W  registered copy of mem_wdata to WB stage.
- wb_waddr  output  ADDR_W  registered copy of mem_waddr.
- wb_we  output  1  registered copy of mem_we.

Behaviour:
- All three outputs are driven directly from flops; no combinational path from any input to any output.
- Reset, sampled only at posedge clk with rst=1:
  - wb_wdata = 0, wb_waddr = 0, wb_we = WriteDisable (0).
  - The result is a bubble: no register write occurs.
- Normal operation, at posedge clk with rst=0:
  - wb_wdata <= mem_wdata; wb_waddr <= mem_waddr; wb_we <= mem_we.
  - Latency is exactly 1 cycle; throughput is 1 request per cycle.
- Between edges, outputs hold their last value regardless of input changes.
- Reset priority: rst=1 overrides any input values in the same edge, including mem_we=1.
- Reset mid-operation: the pending request is discarded; after the reset edge wb_we=0 and wb_waddr/wb_wdata=0. The first edge with rst=0 captures the then-current inputs.
- Power-up: outputs are undefined until the first rising edge with rst=1. The system guarantees reset is held for at least one edge.
- When mem_we=0, wb_wdata and wb_waddr still follow their inputs. Consumers must gate on wb_we.
- There is no internal hold; a value in flight cannot be frozen.

Decomposition:
- Shared defines/package (the project defines file):
  - RstEnable/RstDisable and WriteEnable/WriteDisable constants.
  - Word width 16 and register-address width 4.
  - Zero word and zero register address used as reset values.
- No sub-module is required: a single always block at the clock edge, with a reset branch and a transfer branch.
- The implementation is small (well under 120 lines); keep it a flat module.

Test Plan:
- Clock period 10 ns with rising edges at 5, 15, 25, 35, 45, 55 ns. Inputs are changed on falling edges.
- rst=1 with all inputs 0 through edge at 5 ns -> wb_wdata=0, wb_waddr=0, wb_we=0.
- rst=0, mem_waddr=1, mem_wdata=1, mem_we=1 applied at 10 ns -> after edge at 15 ns: wb_waddr=1, wb_wdata=1, wb_we=1. Outputs are unchanged before that edge.
- mem_waddr=0, mem_wdata=0, mem_we=0 at 20 ns -> after 25 ns: all outputs 0.
- mem_waddr=2, mem_wdata=2, mem_we=1 at 30 ns -> after 35 ns: wb_waddr=2, wb_wdata=2, wb_we=1. Hold inputs; after 45 ns the outputs still read 2/2/1.
- Assert rst=1 at 50 ns while mem_we=1, mem_waddr=2, mem_wdata=2 -> after 55 ns: wb_we=0, wb_waddr=0, wb_wdata=0 (reset wins).
- Drive mem_wdata=16'hFFFF, mem_waddr=4'hF, mem_we=1, then release rst -> next edge: wb_wdata=16'hFFFF, wb_waddr=15, wb_we=1. This shows full width with no truncation.

Source files
------------

// File: rtl/mem_wb_pkg.sv
// Shared mcpu constants: control encodings, word/address widths, reset values.
package mem_wb_pkg;

  localparam int WORD_W = 16;
  localparam int REG_ADDR_W = 4;

  localparam logic RST_ENABLE = 1'b1;
  localparam logic RST_DISABLE = 1'b0;
  localparam logic WRITE_ENABLE = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;

  localparam logic [WORD_W-1:0] ZERO_WORD = '0;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG_ADDR = '0;

endpackage

// File: rtl/mem_wb.sv
// MEM/WB pipeline boundary: registers the register-file write request from
// the memory stage and presents it to write-back one cycle later.
module mem_wb
  import mem_wb_pkg::*;
#(
  parameter int DATA_W = WORD_W,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic [ADDR_W-1:0] mem_waddr,
  input  logic              mem_we,
  output logic [DATA_W-1:0] wb_wdata,
  output logic [ADDR_W-1:0] wb_waddr,
  output logic              wb_we
);

  // Reset inserts a bubble (write disabled, zeroed fields); otherwise transfer.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      wb_wdata <= '0;
      wb_waddr <= '0;
      wb_we    <= WRITE_DISABLE;
    end else begin
      wb_wdata <= mem_wdata;
      wb_waddr <= mem_waddr;
      wb_we    <= mem_we;
    end
  end

endmodule

// File: tb/tb_mem_wb.sv
// Directed bench for mem_wb: reset, transfer, hold, reset priority, full width.
module tb_mem_wb;

  logic        clk;
  logic        rst;
  logic [15:0] mem_wdata;
  logic [3:0]  mem_waddr;
  logic        mem_we;
  logic [15:0] wb_wdata;
  logic [3:0]  wb_waddr;
  logic        wb_we;

  int errors = 0;
  int checks = 0;

  mem_wb dut (
    .clk       (clk),
    .rst       (rst),
    .mem_wdata (mem_wdata),
    .mem_waddr (mem_waddr),
    .mem_we    (mem_we),
    .wb_wdata  (wb_wdata),
    .wb_waddr  (wb_waddr),
    .wb_we     (wb_we)
  );

  // Rising edges at 5, 15, 25, ...; falling edges at 10, 20, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [15:0] d, input logic [3:0] a, input logic w);
    chk({tag, ".wdata"}, {16'h0, wb_wdata}, {16'h0, d});
    chk({tag, ".waddr"}, {28'h0, wb_waddr}, {28'h0, a});
    chk({tag, ".we"},    {31'h0, wb_we},    {31'h0, w});
  endtask

  initial begin
    rst = 1'b1; mem_wdata = 16'h0; mem_waddr = 4'h0; mem_we = 1'b0;

    // Reset through edge at 5 ns
    @(negedge clk);
    chk_all("reset", 16'h0, 4'h0, 1'b0);

    // 10 ns: first request; outputs must not move before the edge
    rst = 1'b0; mem_wdata = 16'h1; mem_waddr = 4'h1; mem_we = 1'b1;
    #1 chk_all("pre_edge_hold", 16'h0, 4'h0, 1'b0);
    @(negedge clk);
    chk_all("req1", 16'h1, 4'h1, 1'b1);

    // 20 ns: all-zero request
    mem_wdata = 16'h0; mem_waddr = 4'h0; mem_we = 1'b0;
    @(negedge clk);
    chk_all("req0", 16'h0, 4'h0, 1'b0);

    // 30 ns: request 2, held across two edges
    mem_wdata = 16'h2; mem_waddr = 4'h2; mem_we = 1'b1;
    @(negedge clk);
    chk_all("req2", 16'h2, 4'h2, 1'b1);
    @(negedge clk);
    chk_all("req2_held", 16'h2, 4'h2, 1'b1);

    // 50 ns: reset wins over an active write request
    rst = 1'b1;
    @(negedge clk);
    chk_all("reset_prio", 16'h0, 4'h0, 1'b0);

    // 60 ns: full-width values, release reset
    mem_wdata = 16'hFFFF; mem_waddr = 4'hF; mem_we = 1'b1; rst = 1'b0;
    @(negedge clk);
    chk_all("full_width", 16'hFFFF, 4'hF, 1'b1);

    // Data/address still follow inputs when write is disabled
    mem_wdata = 16'hA5C3; mem_waddr = 4'h7; mem_we = 1'b0;
    @(negedge clk);
    chk_all("we_off_follow", 16'hA5C3, 4'h7, 1'b0);

    // Input change mid-cycle does not reach outputs before the edge
    mem_wdata = 16'h5A3C; mem_waddr = 4'h9; mem_we = 1'b1;
    #2 mem_wdata = 16'h1234;
    #1 chk_all("mid_cycle_hold", 16'hA5C3, 4'h7, 1'b0);
    @(negedge clk);
    chk_all("mid_cycle_capture", 16'h1234, 4'h9, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
